radix8_mul_seq: RTL and testbench

RADIX8_MUL_SEQ -- requirements
Module: radix8_mul_seq

---
 rtl/radix8_mul_seq_if.sv | 19 +
 rtl/radix8_mul_seq.sv | 116 +++++++++++
 tb/tb_radix8_mul_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/radix8_mul_seq_if.sv
// rtl/radix8_mul_seq_if.sv - start/operand/result bundle for the radix-8 Booth multiplier
interface radix8_mul_seq_if;
  logic        iStart;
  logic [7:0]  iA;
  logic [7:0]  iB;
  logic        oBusy;
  logic        oDone;
  logic [15:0] oProd;

  modport master (
    output iStart, iA, iB,
    input  oBusy, oDone, oProd
  );

  modport slave (
    input  iStart, iA, iB,
    output oBusy, oDone, oProd
  );
endinterface

// File: rtl/radix8_mul_seq.sv
// rtl/radix8_mul_seq.sv - sequential 8x8 unsigned multiplier, radix-8 Booth, three digit steps
// Optional zero-operand skip is enabled by defining RADIX8_MUL_ZERO_SKIP_EN.
module radix8_mul_seq (
  input  logic            clk,
  input  logic            rst,
  radix8_mul_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PREP, ITER, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  cnt;
  logic [7:0]  a_reg;
  logic [7:0]  b_reg;
  logic [9:0]  a3;
  logic [17:0] acc;
  logic [17:0] acc_nxt;
  logic [15:0] prod;
  logic        accept;
  logic        zero_op;
  logic [9:0]  bx;
  logic [3:0]  grp;
  logic        neg;
  logic [17:0] mag;
  logic [17:0] term;
  logic [17:0] shifted;

  assign accept = ((state == IDLE) || (state == DONE)) && bus.iStart;

`ifdef RADIX8_MUL_ZERO_SKIP_EN
  assign zero_op = (bus.iA == 8'd0) || (bus.iB == 8'd0);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (bus.iStart) state_nxt = zero_op ? DONE : PREP;
        else            state_nxt = IDLE;
      end
      PREP:    state_nxt = ITER;
      ITER:    if (cnt == 2'd2) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Multiplier padded with b[-1]=0 below and b[8]=0 above so every group is 4 bits.
  always_comb begin
    bx = {1'b0, b_reg, 1'b0};
    case (cnt)
      2'd1:    grp = bx[6:3];
      2'd2:    grp = bx[9:6];
      default: grp = bx[3:0];
    endcase
    neg = grp[3];
    case (grp)
      4'b0001, 4'b0010, 4'b1101, 4'b1110: mag = {10'd0, a_reg};
      4'b0011, 4'b0100, 4'b1011, 4'b1100: mag = {9'd0, a_reg, 1'b0};
      4'b0101, 4'b0110, 4'b1001, 4'b1010: mag = {8'd0, a3};
      4'b0111, 4'b1000:                   mag = {8'd0, a_reg, 2'b00};
      default:                            mag = 18'd0;
    endcase
    term = neg ? (18'd0 - mag) : mag;
    case (cnt)
      2'd1:    shifted = {term[14:0], 3'b000};
      2'd2:    shifted = {term[11:0], 6'b000000};
      default: shifted = term;
    endcase
    acc_nxt = acc + shifted;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= 2'd0;
      a_reg <= 8'd0;
      b_reg <= 8'd0;
      a3    <= 10'd0;
      acc   <= 18'd0;
      prod  <= 16'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            a_reg <= bus.iA;
            b_reg <= bus.iB;
            acc   <= 18'd0;
            cnt   <= 2'd0;
            if (zero_op) prod <= 16'd0;
          end
        end
        PREP: begin
          a3  <= {2'b00, a_reg} + {1'b0, a_reg, 1'b0};
          cnt <= 2'd0;
        end
        ITER: begin
          acc <= acc_nxt;
          cnt <= cnt + 2'd1;
          // Last digit: the completed sum lands in prod on the same edge that enters DONE.
          if (cnt == 2'd2) prod <= acc_nxt[15:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.oBusy = (state != IDLE);
  assign bus.oDone = (state == DONE);
  assign bus.oProd = prod;
endmodule

// File: tb/tb_radix8_mul_seq.sv
// tb/tb_radix8_mul_seq.sv - randomized self-checking bench for radix8_mul_seq against A*B
module tb_radix8_mul_seq;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   last_prod;

  radix8_mul_seq_if mif ();

  radix8_mul_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int latency(input int a, input int b);
`ifdef RADIX8_MUL_ZERO_SKIP_EN
    if (a == 0 || b == 0) return 1;
`endif
    return 5;
  endfunction

  // Entered at a negedge with the DUT in IDLE or DONE; returns at the negedge of DONE.
  task automatic issue(input int a, input int b, input bit hold);
    int lat;
    lat = latency(a, b);
    mif.iStart = 1'b1;
    mif.iA     = a[7:0];
    mif.iB     = b[7:0];
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk($sformatf("busy a=%0d b=%0d k=%0d", a, b, k), {31'd0, mif.oBusy}, 32'd1);
      chk($sformatf("done a=%0d b=%0d k=%0d", a, b, k), {31'd0, mif.oDone}, (k == lat) ? 32'd1 : 32'd0);
      if (k == lat) begin
        chk($sformatf("prod a=%0d b=%0d", a, b), {16'd0, mif.oProd}, a * b);
        mif.iStart = 1'b0;
        last_prod  = a * b;
      end else begin
        mif.iStart = hold;
        mif.iA     = 8'($urandom);
        mif.iB     = 8'($urandom);
      end
    end
  endtask

  task automatic idle_check(input string tag);
    mif.iStart = 1'b0;
    @(negedge clk);
    chk({tag, " idle busy"}, {31'd0, mif.oBusy}, 32'd0);
    chk({tag, " idle done"}, {31'd0, mif.oDone}, 32'd0);
    chk({tag, " idle prod"}, {16'd0, mif.oProd}, last_prod);
  endtask

  initial begin
    int corners [6];
    int a;
    int b;
    corners = '{0, 1, 2, 127, 128, 255};
    total = 0;
    bad = 0;
    last_prod = 0;
    rst = 1'b0;
    mif.iStart = 1'b0;
    mif.iA = 8'd0;
    mif.iB = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'd0, mif.oBusy}, 32'd0);
    chk("reset done", {31'd0, mif.oDone}, 32'd0);
    chk("reset prod", {16'd0, mif.oProd}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    issue(255, 255, 1'b0);
    idle_check("max");

    issue(200, 3, 1'b0);
    issue(7, 146, 1'b0);
    idle_check("b2b");

    issue(0, 77, 1'b0);
    idle_check("a0");
    issue(77, 0, 1'b0);
    idle_check("b0");

    issue(13, 11, 1'b1);
    idle_check("hold");

    // Abort in the second ITER cycle.
    mif.iStart = 1'b1;
    mif.iA = 8'd5;
    mif.iB = 8'd6;
    @(negedge clk);
    mif.iStart = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort busy", {31'd0, mif.oBusy}, 32'd0);
    chk("abort done", {31'd0, mif.oDone}, 32'd0);
    chk("abort prod", {16'd0, mif.oProd}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort no done", {31'd0, mif.oDone}, 32'd0);
    end
    rst = 1'b1;
    last_prod = 0;
    idle_check("post abort");
    issue(16, 16, 1'b0);
    idle_check("post abort op");

    foreach (corners[i]) begin
      foreach (corners[j]) begin
        issue(corners[i], corners[j], 1'b0);
      end
    end
    idle_check("corners");

    for (int n = 0; n < 1500; n++) begin
      a = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      issue(a, b, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) idle_check("rand");
    end
    idle_check("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
